// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//   Circular in-order buffer of 2**ROB_WIDTH_BIT entries. Dispatch allocates
//   entries at the tail; the RS ALU and LSB result buses mark entries done;
//   the oldest entry retires to the register file once its result is known.
//   Two combinational dependency queries let dispatch pick up operands that are
//   already stored or are being broadcast this very cycle.
//
// Ports
//   clk_in, rst_in, rdy_in          clock, async active-high reset, pause
//   flush                           discard every entry (mispredict)
//   alloc_valid/rd/done/value       allocation request from dispatch
//   alloc_rob_id, full, empty       id the next allocation receives, occupancy
//   rs_ready/rob_id/value           RS ALU result bus
//   lsb_ready/rob_id/value          LSB result bus
//   q1_*, q2_*                      operand dependency queries
//   commit_valid/rob_id/rd/value    registered one-cycle retire pulse
// -----------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_WIDTH_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush,

    input  logic                     alloc_valid,
    input  logic [4:0]               alloc_rd,
    input  logic                     alloc_done,
    input  logic [31:0]              alloc_value,
    output logic [ROB_WIDTH_BIT-1:0] alloc_rob_id,
    output logic                     full,
    output logic                     empty,

    input  logic                     rs_ready,
    input  logic [ROB_WIDTH_BIT-1:0] rs_rob_id,
    input  logic [31:0]              rs_value,
    input  logic                     lsb_ready,
    input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
    input  logic [31:0]              lsb_value,

    input  logic [ROB_WIDTH_BIT-1:0] q1_rob_id,
    output logic                     q1_ready,
    output logic [31:0]              q1_value,
    input  logic [ROB_WIDTH_BIT-1:0] q2_rob_id,
    output logic                     q2_ready,
    output logic [31:0]              q2_value,

    output logic                     commit_valid,
    output logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    output logic [4:0]               commit_rd,
    output logic [31:0]              commit_value
);

    localparam int W     = ROB_WIDTH_BIT;
    localparam int DEPTH = 1 << W;

    // Per-entry state
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] r_done;
    logic [4:0]       r_rd    [DEPTH];
    logic [31:0]      r_value [DEPTH];

    logic [W-1:0]     r_head;
    logic [W-1:0]     r_tail;
    logic [W:0]       r_count;

    logic             w_alloc;
    logic             w_commit;
    logic             w_rs_wr;
    logic             w_lsb_wr;
    logic [32:0]      w_q1;
    logic [32:0]      w_q2;

    assign full         = (r_count == (W+1)'(DEPTH));
    assign empty        = (r_count == '0);
    assign alloc_rob_id = r_tail;

    // full is the pre-edge view: a retire on the same edge does not free a slot
    assign w_alloc  = alloc_valid && !full;
    // Retire decision uses registered flags only, so a result seen on a bus
    // this cycle retires on the following edge at the earliest.
    assign w_commit = r_busy[r_head] && r_done[r_head];
    // Results for ids that are not in flight (stale after flush) are dropped
    assign w_rs_wr  = rs_ready  && r_busy[rs_rob_id];
    assign w_lsb_wr = lsb_ready && r_busy[lsb_rob_id];

    // Returns {ready, value}. Stored value beats the RS bus, which beats the LSB bus.
    function automatic logic [32:0] f_query(
        input logic        busy,
        input logic        done,
        input logic [31:0] stored,
        input logic        rs_hit,
        input logic        lsb_hit,
        input logic [31:0] rs_v,
        input logic [31:0] lsb_v
    );
        logic [32:0] res;
        res = '0;
        if (busy) begin
            if (done)         res = {1'b1, stored};
            else if (rs_hit)  res = {1'b1, rs_v};
            else if (lsb_hit) res = {1'b1, lsb_v};
        end
        return res;
    endfunction

    assign w_q1 = f_query(r_busy[q1_rob_id], r_done[q1_rob_id], r_value[q1_rob_id],
                          rs_ready && (rs_rob_id == q1_rob_id),
                          lsb_ready && (lsb_rob_id == q1_rob_id),
                          rs_value, lsb_value);
    assign w_q2 = f_query(r_busy[q2_rob_id], r_done[q2_rob_id], r_value[q2_rob_id],
                          rs_ready && (rs_rob_id == q2_rob_id),
                          lsb_ready && (lsb_rob_id == q2_rob_id),
                          rs_value, lsb_value);

    assign q1_ready = w_q1[32];
    assign q1_value = w_q1[31:0];
    assign q2_ready = w_q2[32];
    assign q2_value = w_q2[31:0];

    // Control state: pointers, occupancy, flags and the retire port.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; later assignments in this block win (alloc
    // after writeback on the same entry).
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy        <= '0;
            r_done        <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            commit_valid  <= 1'b0;
            commit_rob_id <= '0;
            commit_rd     <= '0;
            commit_value  <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                r_busy       <= '0;
                r_head       <= '0;
                r_tail       <= '0;
                r_count      <= '0;
                commit_valid <= 1'b0;
            end else begin
                if (w_rs_wr)  r_done[rs_rob_id]  <= 1'b1;
                if (w_lsb_wr) r_done[lsb_rob_id] <= 1'b1;

                if (w_commit) begin
                    commit_valid   <= 1'b1;
                    commit_rob_id  <= r_head;
                    commit_rd      <= r_rd[r_head];
                    commit_value   <= r_value[r_head];
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + 1'b1;
                end else begin
                    commit_valid   <= 1'b0;
                end

                // Tail slot is free whenever not full, so it never collides
                // with the head being retired.
                if (w_alloc) begin
                    r_busy[r_tail] <= 1'b1;
                    r_done[r_tail] <= alloc_done;
                    r_tail         <= r_tail + 1'b1;
                end

                case ({w_alloc, w_commit})
                    2'b10:   r_count <= r_count + (W+1)'(1);
                    2'b01:   r_count <= r_count - (W+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end else begin
            // Paused: the retire pulse must not repeat
            commit_valid <= 1'b0;
        end
    end

    // Entry payload. NOTE: the rd/value storage has no reset; it is only ever
    // read behind busy/done flags, which are reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush) begin
            if (w_rs_wr)  r_value[rs_rob_id]  <= rs_value;
            // LSB write comes second so it wins a same-id collision
            if (w_lsb_wr) r_value[lsb_rob_id] <= lsb_value;
            if (w_alloc) begin
                r_rd[r_tail]    <= alloc_rd;
                r_value[r_tail] <= alloc_value;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

    localparam int W = 4;
    localparam int N = 16;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          flush;
    logic          alloc_valid;
    logic [4:0]    alloc_rd;
    logic          alloc_done;
    logic [31:0]   alloc_value;
    logic [W-1:0]  alloc_rob_id;
    logic          full;
    logic          empty;
    logic          rs_ready;
    logic [W-1:0]  rs_rob_id;
    logic [31:0]   rs_value;
    logic          lsb_ready;
    logic [W-1:0]  lsb_rob_id;
    logic [31:0]   lsb_value;
    logic [W-1:0]  q1_rob_id;
    logic          q1_ready;
    logic [31:0]   q1_value;
    logic [W-1:0]  q2_rob_id;
    logic          q2_ready;
    logic [31:0]   q2_value;
    logic          commit_valid;
    logic [W-1:0]  commit_rob_id;
    logic [4:0]    commit_rd;
    logic [31:0]   commit_value;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    reorder_buffer #(.ROB_WIDTH_BIT(W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_done(alloc_done),
        .alloc_value(alloc_value), .alloc_rob_id(alloc_rob_id),
        .full(full), .empty(empty),
        .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .q1_rob_id(q1_rob_id), .q1_ready(q1_ready), .q1_value(q1_value),
        .q2_rob_id(q2_rob_id), .q2_ready(q2_ready), .q2_value(q2_value),
        .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
        .commit_rd(commit_rd), .commit_value(commit_value)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        alloc_rd    = '0;
        alloc_done  = 1'b0;
        alloc_value = '0;
        rs_ready    = 1'b0;
        rs_rob_id   = '0;
        rs_value    = '0;
        lsb_ready   = 1'b0;
        lsb_rob_id  = '0;
        lsb_value   = '0;
        q1_rob_id   = '0;
        q2_rob_id   = '0;
    endtask

    task automatic do_reset();
        idle();
        rdy_in = 1'b1;
        rst_in = 1'b1;
        #3;
        rst_in = 1'b0;
        #1;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic done, input logic [31:0] val);
        alloc_valid = 1'b1;
        alloc_rd    = rd;
        alloc_done  = done;
        alloc_value = val;
        tick();
        alloc_valid = 1'b0;
    endtask

    // ---------------- query table ----------------
    typedef struct {
        logic [W-1:0] q_id;
        logic         rs_rdy;
        logic [W-1:0] rs_id;
        logic [31:0]  rs_val;
        logic         lsb_rdy;
        logic [W-1:0] lsb_id;
        logic [31:0]  lsb_val;
        logic         exp_rdy;
        logic [31:0]  exp_val;
    } qvec_t;

    qvec_t vecs[8];

    // ---------------- reference model ----------------
    typedef struct {
        logic [W-1:0] id;
        logic [4:0]   rd;
        bit           done;
        logic [31:0]  val;
    } ment_t;

    ment_t mq[$];
    int    m_tail;

    function automatic int m_find(input logic [W-1:0] id);
        foreach (mq[i]) if (mq[i].id == id) return i;
        return -1;
    endfunction

    function automatic logic [32:0] m_query(input logic [W-1:0] id);
        int k;
        k = m_find(id);
        if (k < 0)                              return 33'd0;
        if (mq[k].done)                         return {1'b1, mq[k].val};
        if (rs_ready && rs_rob_id == id)        return {1'b1, rs_value};
        if (lsb_ready && lsb_rob_id == id)      return {1'b1, lsb_value};
        return 33'd0;
    endfunction

    function automatic logic [W-1:0] pick_id();
        if (mq.size() > 0 && ($urandom % 4) != 0)
            return mq[$urandom_range(0, mq.size() - 1)].id;
        return W'($urandom % N);
    endfunction

    initial begin
        logic [32:0] eq;
        bit          exp_cv;
        ment_t       front;
        int          k;

        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle();
        #12;

        // ---- 1. reset mid-run with 5 busy entries ----
        do_reset();
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        check("reset_alloc_id", 32'(alloc_rob_id), 32'd0);
        check("reset_commit_valid", 32'(commit_valid), 32'd0);
        for (int i = 0; i < 5; i++) alloc(5'(i + 1), 1'b0, 32'(i));
        check("pre_rst_alloc_id", 32'(alloc_rob_id), 32'd5);
        check("pre_rst_empty", 32'(empty), 32'd0);
        #2;
        rst_in = 1'b1;
        #1;
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_full", 32'(full), 32'd0);
        check("midrst_commit_valid", 32'(commit_valid), 32'd0);
        check("midrst_alloc_id", 32'(alloc_rob_id), 32'd0);
        rst_in = 1'b0;

        // ---- 2. done-at-dispatch alloc retires after the following edge ----
        do_reset();
        alloc(5'd3, 1'b1, 32'h11);
        check("t2_no_commit_edgeN", 32'(commit_valid), 32'd0);
        tick();
        check("t2_commit_valid", 32'(commit_valid), 32'd1);
        check("t2_commit_rd", 32'(commit_rd), 32'd3);
        check("t2_commit_value", commit_value, 32'h11);
        check("t2_commit_id", 32'(commit_rob_id), 32'd0);
        tick();
        check("t2_pulse_one_cycle", 32'(commit_valid), 32'd0);
        check("t2_empty_after", 32'(empty), 32'd1);

        // ---- 3. out-of-order completion, in-order retire ----
        do_reset();
        alloc(5'd1, 1'b0, 32'h0);
        alloc(5'd2, 1'b0, 32'h0);
        lsb_ready = 1'b1; lsb_rob_id = 4'd1; lsb_value = 32'hAA;
        tick();
        lsb_ready = 1'b0;
        check("t3_id1_not_committed", 32'(commit_valid), 32'd0);
        rs_ready = 1'b1; rs_rob_id = 4'd0; rs_value = 32'h55;
        tick();
        rs_ready = 1'b0;
        check("t3_no_bypass", 32'(commit_valid), 32'd0);
        tick();
        check("t3_c0_valid", 32'(commit_valid), 32'd1);
        check("t3_c0_id", 32'(commit_rob_id), 32'd0);
        check("t3_c0_value", commit_value, 32'h55);
        tick();
        check("t3_c1_valid", 32'(commit_valid), 32'd1);
        check("t3_c1_id", 32'(commit_rob_id), 32'd1);
        check("t3_c1_rd", 32'(commit_rd), 32'd2);
        check("t3_c1_value", commit_value, 32'hAA);
        tick();
        check("t3_done", 32'(commit_valid), 32'd0);

        // ---- 4. full, ignored alloc, wrap and commit+alloc on one edge ----
        do_reset();
        for (int i = 0; i < N; i++) alloc(5'(i), 1'b0, 32'(i));
        check("t4_full", 32'(full), 32'd1);
        check("t4_tail_wrapped", 32'(alloc_rob_id), 32'd0);
        alloc(5'd9, 1'b1, 32'hDEAD);
        check("t4_17th_ignored_full", 32'(full), 32'd1);
        check("t4_17th_ignored_tail", 32'(alloc_rob_id), 32'd0);
        rs_ready = 1'b1; rs_rob_id = 4'd0; rs_value = 32'h100;
        tick();
        rs_ready = 1'b0;
        rs_ready = 1'b1; rs_rob_id = 4'd1; rs_value = 32'h101;
        alloc(5'd9, 1'b1, 32'hBEEF);   // commit id0, alloc blocked by pre-edge full
        rs_ready = 1'b0;
        check("t4_c0", 32'(commit_valid), 32'd1);
        check("t4_c0_value", commit_value, 32'h100);
        check("t4_not_full", 32'(full), 32'd0);
        check("t4_tail_still0", 32'(alloc_rob_id), 32'd0);
        alloc(5'd10, 1'b0, 32'h0);     // commit id1 + alloc id0 same edge
        check("t4_c1_id", 32'(commit_rob_id), 32'd1);
        check("t4_count_held", 32'(full), 32'd0);
        check("t4_tail_1", 32'(alloc_rob_id), 32'd1);
        alloc(5'd11, 1'b0, 32'h0);
        check("t4_full_again", 32'(full), 32'd1);

        // ---- 5. query bypass and same-id writeback collision ----
        do_reset();
        for (int i = 0; i < 3; i++) alloc(5'(i + 4), 1'b0, 32'h0);
        q1_rob_id = 4'd2; q2_rob_id = 4'd2;
        #1;
        check("t5_pending", 32'(q1_ready), 32'd0);
        rs_ready = 1'b1; rs_rob_id = 4'd2; rs_value = 32'h7;
        #1;
        check("t5_q1_ready", 32'(q1_ready), 32'd1);
        check("t5_q1_value", q1_value, 32'h7);
        check("t5_q2_value", q2_value, 32'h7);
        lsb_ready = 1'b1; lsb_rob_id = 4'd2; lsb_value = 32'h99;
        tick();
        rs_ready = 1'b0; lsb_ready = 1'b0;
        #1;
        check("t5_stored_ready", 32'(q1_ready), 32'd1);
        check("t5_lsb_wins", q1_value, 32'h99);

        // ---- table: query priority and miss cases ----
        // State: id0 pending, id1 done 0x200, id2 pending, id3 free
        vecs[0] = '{4'd1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 32'h200};
        vecs[1] = '{4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0};
        vecs[2] = '{4'd0, 1'b1, 4'd0, 32'h5, 1'b0, 4'd0, 32'h0, 1'b1, 32'h5};
        vecs[3] = '{4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 32'h6, 1'b1, 32'h6};
        vecs[4] = '{4'd0, 1'b1, 4'd0, 32'h5, 1'b1, 4'd0, 32'h6, 1'b1, 32'h5};
        vecs[5] = '{4'd1, 1'b1, 4'd1, 32'h9, 1'b0, 4'd0, 32'h0, 1'b1, 32'h200};
        vecs[6] = '{4'd3, 1'b1, 4'd3, 32'h7, 1'b1, 4'd3, 32'h8, 1'b0, 32'h0};
        vecs[7] = '{4'd2, 1'b1, 4'd0, 32'h5, 1'b1, 4'd1, 32'h6, 1'b0, 32'h0};
        do_reset();
        for (int i = 0; i < 3; i++) alloc(5'(i + 1), 1'b0, 32'h0);
        lsb_ready = 1'b1; lsb_rob_id = 4'd1; lsb_value = 32'h200;
        tick();
        idle();
        rdy_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            q1_rob_id  = vecs[i].q_id;    q2_rob_id  = vecs[i].q_id;
            rs_ready   = vecs[i].rs_rdy;  rs_rob_id  = vecs[i].rs_id;  rs_value  = vecs[i].rs_val;
            lsb_ready  = vecs[i].lsb_rdy; lsb_rob_id = vecs[i].lsb_id; lsb_value = vecs[i].lsb_val;
            #1;
            check($sformatf("tbl%0d_q1_ready", i), 32'(q1_ready), 32'(vecs[i].exp_rdy));
            check($sformatf("tbl%0d_q1_value", i), q1_value, vecs[i].exp_val);
            check($sformatf("tbl%0d_q2_value", i), q2_value, vecs[i].exp_val);
        end
        idle();
        rdy_in = 1'b1;

        // ---- 6. flush and pause ----
        do_reset();
        for (int i = 0; i < 4; i++) alloc(5'(i + 1), 1'b0, 32'h0);
        check("t6_pre_flush_empty", 32'(empty), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t6_flush_empty", 32'(empty), 32'd1);
        check("t6_flush_alloc_id", 32'(alloc_rob_id), 32'd0);
        check("t6_flush_commit", 32'(commit_valid), 32'd0);
        alloc(5'd7, 1'b1, 32'h33);
        tick();
        check("t6_commit", 32'(commit_valid), 32'd1);
        alloc(5'd8, 1'b1, 32'h44);     // id1, done
        rdy_in = 1'b0;
        alloc_valid = 1'b1; alloc_rd = 5'd9; alloc_done = 1'b1; alloc_value = 32'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6_pause%0d_commit", i), 32'(commit_valid), 32'd0);
            check($sformatf("t6_pause%0d_tail", i), 32'(alloc_rob_id), 32'd2);
            check($sformatf("t6_pause%0d_empty", i), 32'(empty), 32'd0);
        end
        idle();
        rdy_in = 1'b1;
        tick();
        check("t6_resume_commit", 32'(commit_valid), 32'd1);
        check("t6_resume_value", commit_value, 32'h44);

        // ---- randomized run against the queue model ----
        do_reset();
        mq.delete();
        m_tail = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy_in      = ($urandom % 8) != 0;
            flush       = ($urandom % 80) == 0;
            alloc_valid = ((cyc / 200) % 2 == 0) ? (($urandom % 4) != 0) : (($urandom % 3) == 0);
            alloc_rd    = 5'($urandom);
            alloc_done  = ($urandom % 4) == 0;
            alloc_value = $urandom;
            rs_ready    = ($urandom % 2) != 0;
            rs_rob_id   = pick_id();
            rs_value    = $urandom;
            lsb_ready   = ($urandom % 2) != 0;
            lsb_rob_id  = pick_id();
            lsb_value   = $urandom;
            q1_rob_id   = pick_id();
            q2_rob_id   = pick_id();
            #1;
            check("rnd_full", 32'(full), 32'(mq.size() == N));
            check("rnd_empty", 32'(empty), 32'(mq.size() == 0));
            check("rnd_alloc_id", 32'(alloc_rob_id), 32'(m_tail));
            eq = m_query(q1_rob_id);
            check("rnd_q1_ready", 32'(q1_ready), 32'(eq[32]));
            check("rnd_q1_value", q1_value, eq[31:0]);
            eq = m_query(q2_rob_id);
            check("rnd_q2_ready", 32'(q2_ready), 32'(eq[32]));
            check("rnd_q2_value", q2_value, eq[31:0]);

            exp_cv = 1'b0;
            front  = '{default: '0};
            if (rdy_in) begin
                if (flush) begin
                    mq.delete();
                    m_tail = 0;
                end else begin
                    bit was_full;
                    was_full = (mq.size() == N);
                    if (mq.size() > 0 && mq[0].done) begin
                        exp_cv = 1'b1;
                        front  = mq[0];
                    end
                    if (rs_ready) begin
                        k = m_find(rs_rob_id);
                        if (k >= 0) begin mq[k].done = 1'b1; mq[k].val = rs_value; end
                    end
                    if (lsb_ready) begin
                        k = m_find(lsb_rob_id);
                        if (k >= 0) begin mq[k].done = 1'b1; mq[k].val = lsb_value; end
                    end
                    if (exp_cv) void'(mq.pop_front());
                    if (alloc_valid && !was_full) begin
                        mq.push_back('{W'(m_tail), alloc_rd, alloc_done, alloc_value});
                        m_tail = (m_tail + 1) % N;
                    end
                end
            end
            tick();
            check("rnd_commit_valid", 32'(commit_valid), 32'(exp_cv));
            if (exp_cv) begin
                check("rnd_commit_id", 32'(commit_rob_id), 32'(front.id));
                check("rnd_commit_rd", 32'(commit_rd), 32'(front.rd));
                check("rnd_commit_value", commit_value, front.val);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
